// File: rtl/raster_pkg.sv
// Shared rasterizer definitions: fixed-point coordinate type, walker states and
// the floor/clamp helpers used on the bounding-box accept path.
package raster_pkg;

    localparam int unsigned DefFracBits = 6;
    localparam int unsigned DefScreenW  = 640;
    localparam int unsigned DefScreenH  = 480;
    localparam int unsigned CoordW      = 16;

    typedef logic [CoordW-1:0] coord_t;

    typedef enum logic [0:0] {StIdle, StWalk} walk_state_e;

    // Drop the fractional part so the coordinate lands on a pixel corner.
    function automatic coord_t floor_fix(input coord_t v, input int unsigned frac_bits);
        coord_t mask;
        mask = '1;
        mask = mask << frac_bits;
        return v & mask;
    endfunction

    function automatic coord_t clamp_fix(input coord_t v, input coord_t max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bbox_sample_walker.sv
// Accepts one pixel-aligned bounding box, clips it to the screen and emits the
// centre of every covered pixel in raster order, one per handshake.
module bbox_sample_walker
    import raster_pkg::*;
#(
    parameter int unsigned FRAC_BITS = DefFracBits,
    parameter int unsigned SCREEN_W  = DefScreenW,
    parameter int unsigned SCREEN_H  = DefScreenH
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [15:0]  XMIN,
    input  logic [15:0]  XMAX,
    input  logic [15:0]  YMIN,
    input  logic [15:0]  YMAX,
    input  logic         bbox_valid,
    output logic         bbox_ready,
    output logic [15:0]  sample_x,
    output logic [15:0]  sample_y,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         sample_last,
    output logic         busy
);

    localparam coord_t Step      = coord_t'(1 << FRAC_BITS);
    localparam coord_t Half      = coord_t'(1 << (FRAC_BITS - 1));
    localparam coord_t XMaxClamp = coord_t'((SCREEN_W - 1) << FRAC_BITS);
    localparam coord_t YMaxClamp = coord_t'((SCREEN_H - 1) << FRAC_BITS);

    walk_state_e state_q;
    coord_t      cur_x_q, cur_y_q, xmin_q, xmax_q, ymax_q;
    coord_t      sample_x_q, sample_y_q;
    logic        sample_valid_q, sample_last_q;

    coord_t acc_xmin, acc_xmax, acc_ymin, acc_ymax;
    logic   acc_degenerate;
    coord_t nxt_x, nxt_y;
    logic   row_end;

    always_comb begin
        acc_xmin       = floor_fix(XMIN, FRAC_BITS);
        acc_ymin       = floor_fix(YMIN, FRAC_BITS);
        acc_xmax       = clamp_fix(floor_fix(XMAX, FRAC_BITS), XMaxClamp);
        acc_ymax       = clamp_fix(floor_fix(YMAX, FRAC_BITS), YMaxClamp);
        acc_degenerate = (acc_xmin > acc_xmax) || (acc_ymin > acc_ymax);
        row_end        = (cur_x_q == xmax_q);
        nxt_x          = row_end ? xmin_q : cur_x_q + Step;
        nxt_y          = row_end ? cur_y_q + Step : cur_y_q;
    end

    // Sample outputs are registered alongside the cursor so they hold across stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= StIdle;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            xmin_q         <= '0;
            xmax_q         <= '0;
            ymax_q         <= '0;
            sample_x_q     <= '0;
            sample_y_q     <= '0;
            sample_valid_q <= 1'b0;
            sample_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bbox_valid) begin
                        xmin_q <= acc_xmin;
                        xmax_q <= acc_xmax;
                        ymax_q <= acc_ymax;
                        if (!acc_degenerate) begin
                            state_q        <= StWalk;
                            cur_x_q        <= acc_xmin;
                            cur_y_q        <= acc_ymin;
                            sample_x_q     <= acc_xmin + Half;
                            sample_y_q     <= acc_ymin + Half;
                            sample_valid_q <= 1'b1;
                            sample_last_q  <= (acc_xmin == acc_xmax) && (acc_ymin == acc_ymax);
                        end
                    end
                end
                StWalk: begin
                    if (sample_ready) begin
                        if (sample_last_q) begin
                            state_q        <= StIdle;
                            sample_valid_q <= 1'b0;
                            sample_last_q  <= 1'b0;
                        end else begin
                            cur_x_q       <= nxt_x;
                            cur_y_q       <= nxt_y;
                            sample_x_q    <= nxt_x + Half;
                            sample_y_q    <= nxt_y + Half;
                            sample_last_q <= (nxt_x == xmax_q) && (nxt_y == ymax_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bbox_ready   = (state_q == StIdle);
    assign busy         = (state_q == StWalk);
    assign sample_x     = sample_x_q;
    assign sample_y     = sample_y_q;
    assign sample_valid = sample_valid_q;
    assign sample_last  = sample_last_q;

endmodule

// File: doc/bbox_sample_walker.md
# bbox_sample_walker

Consumer side of the triangle bounding-box interface. Accepts one bounding box (XMIN/XMAX/YMIN/YMAX, unsigned 10.6 fixed point, pixel-aligned by the rounding stage), clips it to the screen, and walks every covered pixel in raster order. It emits one pixel-centre sample coordinate per handshake to the downstream edge/sample test.

## Interface
Parameters:
- FRAC_BITS, 6, fractional bits of the fixed-point format; one pixel step = 1<<FRAC_BITS
- SCREEN_W, 640, screen width in pixels; last column = SCREEN_W-1
- SCREEN_H, 480, screen height in pixels; last row = SCREEN_H-1

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST_N  in  1  asynchronous, active-low reset
- XMIN, XMAX, YMIN, YMAX  in  16 each  bounding box, unsigned 10.6
- bbox_valid  in  1  box on XMIN..YMAX is valid
- bbox_ready  out  1  walker can accept a box
- sample_x, sample_y  out  16 each  pixel-centre sample, unsigned 10.6
- sample_valid  out  1  sample outputs valid
- sample_ready  in  1  downstream accepts sample
- sample_last  out  1  current sample is the final one of the box
- busy  out  1  walk in progress

## Operation
- States: IDLE, WALK.
- IDLE: bbox_ready=1, sample_valid=0. On bbox_valid&&bbox_ready, latch the box:
  - Truncate the low FRAC_BITS of every input to zero (floor).
  - Clamp XMAX to (SCREEN_W-1)<<FRAC_BITS and YMAX to (SCREEN_H-1)<<FRAC_BITS.
  - Degenerate (latched XMIN>XMAX or YMIN>YMAX after clamp): stay in IDLE and emit nothing.
  - Otherwise: cur_x=XMIN, cur_y=YMIN, go to WALK.
- WALK: sample_valid=1, sample_x=cur_x+(1<<(FRAC_BITS-1)), sample_y=cur_y+(1<<(FRAC_BITS-1)).
  - sample_last=1 when cur_x==xmax && cur_y==ymax.
  - On sample_valid&&sample_ready: if not the last sample, advance.
    - If cur_x==xmax: cur_x=xmin and cur_y+=1<<FRAC_BITS.
    - Else: cur_x+=1<<FRAC_BITS.
  - On the last sample: go to IDLE.
- Order: x inner, y outer, both ascending.
- Arithmetic is 16-bit unsigned. Clamping guarantees cur+step never wraps.
- sample_x/sample_y/sample_last are held stable while sample_valid&&!sample_ready.
- bbox_ready = (state==IDLE), a registered state decode. bbox_valid in WALK is ignored and stays pending upstream.
- busy = (state==WALK).

## Timing
- Reset (RST_N low, asynchronous): state=IDLE, cur/latched box=0, sample_x=sample_y=0, sample_valid=0, sample_last=0, busy=0, bbox_ready=1 (IDLE).
- Reset mid-walk aborts immediately with no further samples. After release the block is in IDLE.
- Latency: box accepted at edge N gives first sample_valid after edge N; the first sample is presented in cycle N+1.
- Throughput: one sample per cycle while sample_ready=1.
- The last sample accepted at edge M sets bbox_ready=1 in cycle M+1. This is one bubble per box, with no overlap between boxes.
- A degenerate box costs one cycle; bbox_ready stays 1.
- A box with n_x×n_y pixels completes in n_x·n_y cycles at full throughput.

## Structure
- Shared package raster_pkg holds:
  - FRAC_BITS, SCREEN_W and SCREEN_H defaults.
  - The 16-bit fixed-point coordinate typedef.
  - Walker state enum {IDLE, WALK}.
  - Clamp and floor functions, also usable by the bounding-box stage.
- Single module, no sub-modules. The clamp/floor logic is combinational on the accept path.

## Test plan
- Box XMIN=0x0080, XMAX=0x0100, YMIN=0x0040, YMAX=0x0080, sample_ready=1 -> 6 samples in consecutive cycles:
  - x sequence 0x00A0, 0x00E0, 0x0120, repeated twice.
  - y 0x0060 for the first three, 0x00A0 for the last three.
  - sample_last on the 6th only; bbox_ready returns the next cycle.
- Single pixel XMIN=XMAX=0x0040, YMIN=YMAX=0x0040 -> exactly one sample (0x0060, 0x0060) with sample_last=1.
- Same 6-sample box, sample_ready toggling 1,0,0,1… -> identical sequence, outputs stable in stalled cycles, no sample duplicated or skipped.
- Degenerate XMIN=0x0100, XMAX=0x0080 -> no sample_valid; bbox_ready stays 1; the next valid box walks normally.
- Clipping XMIN=0x9F80, XMAX=0xFFC0, YMIN=YMAX=0 -> XMAX clamped to 0x9FC0; samples x=0x9FA0, 0x9FE0, then last.
- RST_N asserted during the 3rd sample of a 6-sample walk -> sample_valid drops asynchronously with all outputs at reset values; after release no residual samples appear and bbox_ready=1.
